// File: rtl/fb_conditioner.sv
// Feedback input conditioner: synchronise and deglitch the raw pin, measure the
// rise-to-rise period, keep a 4-sample running average and flag loss of signal.
module fb_conditioner #(
   parameter int unsigned GLITCH_CYCLES = 4,
   parameter int unsigned PERIOD_W      = 20,
   parameter int unsigned NOSIG_CYCLES  = 2000
) (
   input  logic                clk_50,
   input  logic                rst,
   input  logic                fb_u,
   output logic                fb,
   output logic                fb_rise,
   output logic [PERIOD_W-1:0] period,
   output logic                period_stb,
   output logic [PERIOD_W-1:0] period_avg,
   output logic                avg_valid,
   output logic                nosig
);
   localparam int unsigned         SUM_W     = PERIOD_W + 2;
   localparam logic [7:0]          STAB_LAST = 8'(GLITCH_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] PC_MAX    = '1;
   localparam logic [PERIOD_W-1:0] PC_ONE    = PERIOD_W'(1);
   localparam logic [31:0]         NS_MAX    = 32'(NOSIG_CYCLES);
   localparam logic [2:0]          FILL_FULL = 3'd4;

   logic                fb_s0_q, fb_s1_q;
   logic [7:0]          stab_q, stab_d;
   logic                fb_q, fb_d;
   logic                fb_rise_q, fb_rise_d;
   logic [PERIOD_W-1:0] pc_q, pc_d;
   logic [31:0]         ns_q, ns_d;
   logic                armed_q, armed_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                period_stb_q, period_stb_d;
   logic [2:0]          fill_q, fill_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [PERIOD_W-1:0] hist_q [4];
   logic [PERIOD_W-1:0] hist_d [4];
   logic                nosig_hit;

   // NOTE: every variable gets a default at the top of the block so no path can leave it unassigned and infer a latch.
   always_comb begin
      fb_d         = fb_q;
      stab_d       = '0;
      armed_d      = armed_q;
      period_d     = period_q;
      period_stb_d = 1'b0;
      fill_d       = fill_q;
      sum_d        = sum_q;
      hist_d       = hist_q;

      if (fb_s1_q != fb_q) begin
         if (stab_q == STAB_LAST) fb_d = fb_s1_q;
         else                     stab_d = stab_q + 8'd1;
      end
      fb_rise_d = fb_d & ~fb_q;

      pc_d = fb_rise_q ? PC_ONE : ((pc_q == PC_MAX) ? pc_q : pc_q + PC_ONE);
      ns_d = (fb_d != fb_q) ? '0 : ((ns_q == NS_MAX) ? ns_q : ns_q + 32'd1);
      nosig_hit = (ns_d == NS_MAX) && (ns_q != NS_MAX);

      if (fb_rise_q) begin
         if (!armed_q) begin
            armed_d = 1'b1;
         end else if (pc_q != PC_MAX) begin
            period_d     = pc_q;
            period_stb_d = 1'b1;
            hist_d[0]    = pc_q;
            hist_d[1]    = hist_q[0];
            hist_d[2]    = hist_q[1];
            hist_d[3]    = hist_q[2];
            sum_d        = sum_q + SUM_W'(pc_q) - SUM_W'(hist_q[3]);
            fill_d       = (fill_q == FILL_FULL) ? fill_q : fill_q + 3'd1;
         end else begin
            // Overlong gap: the sample is meaningless, restart the average from scratch.
            hist_d = '{default: '0};
            sum_d  = '0;
            fill_d = '0;
         end
      end

      if (nosig_hit) begin
         armed_d = 1'b0;
         hist_d  = '{default: '0};
         sum_d   = '0;
         fill_d  = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         fb_s0_q      <= 1'b0;
         fb_s1_q      <= 1'b0;
         stab_q       <= '0;
         fb_q         <= 1'b0;
         fb_rise_q    <= 1'b0;
         pc_q         <= '0;
         ns_q         <= '0;
         armed_q      <= 1'b0;
         period_q     <= '0;
         period_stb_q <= 1'b0;
         fill_q       <= '0;
         sum_q        <= '0;
         // NOTE: the four-entry history is reset because the running sum subtracts its oldest entry.
         hist_q       <= '{default: '0};
      end else begin
         fb_s0_q      <= fb_u;
         fb_s1_q      <= fb_s0_q;
         stab_q       <= stab_d;
         fb_q         <= fb_d;
         fb_rise_q    <= fb_rise_d;
         pc_q         <= pc_d;
         ns_q         <= ns_d;
         armed_q      <= armed_d;
         period_q     <= period_d;
         period_stb_q <= period_stb_d;
         fill_q       <= fill_d;
         sum_q        <= sum_d;
         hist_q       <= hist_d;
      end
   end

   assign fb         = fb_q;
   assign fb_rise    = fb_rise_q;
   assign period     = period_q;
   assign period_stb = period_stb_q;
   assign period_avg = sum_q[SUM_W-1:2];
   assign avg_valid  = (fill_q == FILL_FULL);
   assign nosig      = (ns_q == NS_MAX);

endmodule
